// File: rtl/l2_ch_arbiter.sv
// Two-master arbiter (m0 = I-side, m1 = D-side) onto a single-outstanding L2 channel.
// Round-robin grant, one transaction in flight, sticky flush serviced between transactions.
module l2_ch_arbiter #(
   parameter int AW = 25,
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          rst,

   input  logic          m0_cmd_valid,
   output logic          m0_cmd_ready,
   input  logic [AW-1:0] m0_cmd_addr,
   input  logic          m0_cmd_we,
   input  logic [2:0]    m0_cmd_size,
   input  logic [DW-1:0] m0_din,
   output logic          m0_valid,
   input  logic          m0_ready,
   output logic [DW-1:0] m0_dout,

   input  logic          m1_cmd_valid,
   output logic          m1_cmd_ready,
   input  logic [AW-1:0] m1_cmd_addr,
   input  logic          m1_cmd_we,
   input  logic [2:0]    m1_cmd_size,
   input  logic [DW-1:0] m1_din,
   output logic          m1_valid,
   input  logic          m1_ready,
   output logic [DW-1:0] m1_dout,

   input  logic          flush_req,
   output logic          flush_ack,

   output logic          l2_ch_cmd_valid,
   input  logic          l2_ch_cmd_ready,
   output logic [AW-1:0] l2_ch_cmd_addr,
   output logic          l2_ch_cmd_we,
   output logic [2:0]    l2_ch_cmd_size,
   output logic [DW-1:0] l2_ch_din,
   input  logic          l2_ch_valid,
   output logic          l2_ch_ready,
   input  logic [DW-1:0] l2_ch_dout,
   output logic          l2_ch_flush
);

   typedef enum logic [1:0] {IDLE, CMD, RESP, FLUSH} state_t;

   state_t        state_q;
   logic          rr_q;
   logic          owner_q;
   logic          flush_pend_q;
   logic          flush_pend_d;
   logic          cmd_valid_q;
   logic          flush_q;

   logic [AW-1:0] addr_q;
   logic [AW-1:0] addr_d;
   logic          we_q;
   logic          we_d;
   logic [2:0]    size_q;
   logic [2:0]    size_d;
   logic [DW-1:0] din_q;
   logic [DW-1:0] din_d;

   logic          idle_free;
   logic          grant0;
   logic          grant1;
   logic          accept;
   logic          in_resp;
   logic          resp_hs;

   // Grant is combinational so the chosen master is accepted in the same IDLE cycle.
   always_comb begin
      idle_free    = !rst && (state_q == IDLE) && !flush_pend_q;
      grant0       = m0_cmd_valid && (!m1_cmd_valid || !rr_q);
      grant1       = m1_cmd_valid && (!m0_cmd_valid ||  rr_q);
      m0_cmd_ready = idle_free && grant0;
      m1_cmd_ready = idle_free && grant1;
      accept       = m0_cmd_ready || m1_cmd_ready;
      flush_pend_d = (state_q == FLUSH) ? flush_req : (flush_pend_q || flush_req);
   end

   always_comb begin
      addr_d = m1_cmd_ready ? m1_cmd_addr : m0_cmd_addr;
      we_d   = m1_cmd_ready ? m1_cmd_we   : m0_cmd_we;
      size_d = m1_cmd_ready ? m1_cmd_size : m0_cmd_size;
      din_d  = m1_cmd_ready ? m1_din      : m0_din;
   end

   // Response path is a pure steer to the owner; the other master sees zeros.
   always_comb begin
      in_resp     = (state_q == RESP);
      l2_ch_ready = in_resp && (owner_q ? m1_ready : m0_ready);
      resp_hs     = l2_ch_valid && l2_ch_ready;
      m0_valid    = in_resp && !owner_q && l2_ch_valid;
      m1_valid    = in_resp &&  owner_q && l2_ch_valid;
      m0_dout     = (in_resp && !owner_q) ? l2_ch_dout : '0;
      m1_dout     = (in_resp &&  owner_q) ? l2_ch_dout : '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         rr_q         <= 1'b0;
         owner_q      <= 1'b0;
         flush_pend_q <= 1'b0;
         cmd_valid_q  <= 1'b0;
         flush_q      <= 1'b0;
      end else begin
         flush_pend_q <= flush_pend_d;
         case (state_q)
            IDLE: begin
               if (flush_pend_q) begin
                  state_q <= FLUSH;
                  flush_q <= 1'b1;
               end else if (accept) begin
                  state_q     <= CMD;
                  owner_q     <= m1_cmd_ready;
                  cmd_valid_q <= 1'b1;
               end
            end
            CMD: begin
               if (l2_ch_cmd_ready) begin
                  state_q     <= RESP;
                  cmd_valid_q <= 1'b0;
               end
            end
            RESP: begin
               // Writes also wait here for the downstream acknowledge.
               if (resp_hs) begin
                  state_q <= IDLE;
                  rr_q    <= ~owner_q;
               end
            end
            FLUSH: begin
               state_q <= IDLE;
               flush_q <= 1'b0;
            end
            default: begin
               state_q     <= IDLE;
               cmd_valid_q <= 1'b0;
               flush_q     <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         addr_q <= addr_d;
         we_q   <= we_d;
         size_q <= size_d;
         din_q  <= din_d;
      end
   end

   // Size stays driven through RESP because the downstream formats dout by it.
   assign l2_ch_cmd_valid = cmd_valid_q;
   assign l2_ch_cmd_addr  = addr_q;
   assign l2_ch_cmd_we    = we_q;
   assign l2_ch_cmd_size  = size_q;
   assign l2_ch_din       = din_q;
   assign l2_ch_flush     = flush_q;
   assign flush_ack       = flush_q;

endmodule

// File: tb/tb_l2_ch_arbiter.sv
// Bench for l2_ch_arbiter: directed scenarios plus random traffic, all cycles checked
// against a transaction-level model of the arbitration and flush rules.
module tb_l2_ch_arbiter;
   localparam int AW = 25;
   localparam int DW = 32;

   logic          clk;
   logic          rst;
   logic          m0_cmd_valid, m0_cmd_ready, m0_cmd_we, m0_valid, m0_ready;
   logic [AW-1:0] m0_cmd_addr;
   logic [2:0]    m0_cmd_size;
   logic [DW-1:0] m0_din, m0_dout;
   logic          m1_cmd_valid, m1_cmd_ready, m1_cmd_we, m1_valid, m1_ready;
   logic [AW-1:0] m1_cmd_addr;
   logic [2:0]    m1_cmd_size;
   logic [DW-1:0] m1_din, m1_dout;
   logic          flush_req, flush_ack;
   logic          l2_ch_cmd_valid, l2_ch_cmd_ready, l2_ch_cmd_we;
   logic [AW-1:0] l2_ch_cmd_addr;
   logic [2:0]    l2_ch_cmd_size;
   logic [DW-1:0] l2_ch_din, l2_ch_dout;
   logic          l2_ch_valid, l2_ch_ready, l2_ch_flush;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: busy/sent describe the one outstanding transaction,
   // owe is an un-serviced flush, fl is the flush cycle, pref the preferred master.
   bit            mb_busy, mb_sent, mb_who, mb_pref, mb_owe, mb_fl;
   logic [AW-1:0] mb_addr;
   bit            mb_we;
   bit [2:0]      mb_size;
   logic [DW-1:0] mb_din;

   l2_ch_arbiter #(.AW(AW), .DW(DW)) dut (
      .clk(clk), .rst(rst),
      .m0_cmd_valid(m0_cmd_valid), .m0_cmd_ready(m0_cmd_ready), .m0_cmd_addr(m0_cmd_addr),
      .m0_cmd_we(m0_cmd_we), .m0_cmd_size(m0_cmd_size), .m0_din(m0_din),
      .m0_valid(m0_valid), .m0_ready(m0_ready), .m0_dout(m0_dout),
      .m1_cmd_valid(m1_cmd_valid), .m1_cmd_ready(m1_cmd_ready), .m1_cmd_addr(m1_cmd_addr),
      .m1_cmd_we(m1_cmd_we), .m1_cmd_size(m1_cmd_size), .m1_din(m1_din),
      .m1_valid(m1_valid), .m1_ready(m1_ready), .m1_dout(m1_dout),
      .flush_req(flush_req), .flush_ack(flush_ack),
      .l2_ch_cmd_valid(l2_ch_cmd_valid), .l2_ch_cmd_ready(l2_ch_cmd_ready),
      .l2_ch_cmd_addr(l2_ch_cmd_addr), .l2_ch_cmd_we(l2_ch_cmd_we),
      .l2_ch_cmd_size(l2_ch_cmd_size), .l2_ch_din(l2_ch_din),
      .l2_ch_valid(l2_ch_valid), .l2_ch_ready(l2_ch_ready), .l2_ch_dout(l2_ch_dout),
      .l2_ch_flush(l2_ch_flush)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic chkw(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // {m1 grant, m0 grant} as the rules dictate for the current inputs.
   function automatic bit [1:0] mgrant();
      bit free;
      free = !rst && !mb_busy && !mb_fl && !mb_owe;
      return {free && m1_cmd_valid && (!m0_cmd_valid ||  mb_pref),
              free && m0_cmd_valid && (!m1_cmd_valid || !mb_pref)};
   endfunction

   task automatic settle();
      bit [1:0] g;
      bit       resp;
      #1;
      g    = mgrant();
      resp = mb_busy && mb_sent;
      chk1("m0_cmd_ready", m0_cmd_ready, g[0]);
      chk1("m1_cmd_ready", m1_cmd_ready, g[1]);
      chk1("cmd_valid", l2_ch_cmd_valid, mb_busy && !mb_sent);
      if (mb_busy && !mb_sent) begin
         chkw("cmd_addr", 32'(l2_ch_cmd_addr), 32'(mb_addr));
         chk1("cmd_we", l2_ch_cmd_we, mb_we);
         chkw("cmd_din", l2_ch_din, mb_din);
      end
      if (mb_busy) chkw("cmd_size", 32'(l2_ch_cmd_size), 32'(mb_size));
      chk1("l2_flush", l2_ch_flush, mb_fl);
      chk1("flush_ack", flush_ack, mb_fl);
      chk1("l2_ready", l2_ch_ready, resp && (mb_who ? m1_ready : m0_ready));
      chk1("m0_valid", m0_valid, resp && !mb_who && l2_ch_valid);
      chk1("m1_valid", m1_valid, resp &&  mb_who && l2_ch_valid);
      if (resp) begin
         chkw("m0_dout", m0_dout, mb_who ? 32'd0 : l2_ch_dout);
         chkw("m1_dout", m1_dout, mb_who ? l2_ch_dout : 32'd0);
      end
   endtask

   task automatic tick();
      bit [1:0] g;
      bit       rdy;
      g   = mgrant();
      rdy = mb_who ? m1_ready : m0_ready;
      if (rst) begin
         mb_busy = 0; mb_sent = 0; mb_fl = 0; mb_owe = 0; mb_pref = 0; mb_who = 0;
      end else if (mb_fl) begin
         mb_fl  = 0;
         mb_owe = flush_req;
      end else begin
         if (!mb_busy && mb_owe) begin
            mb_fl = 1;
         end else if (g != 2'b00) begin
            mb_busy = 1; mb_sent = 0; mb_who = g[1];
            if (g[1]) begin
               mb_addr = m1_cmd_addr; mb_we = m1_cmd_we; mb_size = m1_cmd_size; mb_din = m1_din;
            end else begin
               mb_addr = m0_cmd_addr; mb_we = m0_cmd_we; mb_size = m0_cmd_size; mb_din = m0_din;
            end
         end else if (mb_busy && !mb_sent) begin
            mb_sent = l2_ch_cmd_ready;
         end else if (mb_busy && l2_ch_valid && rdy) begin
            mb_busy = 0;
            mb_pref = !mb_who;
         end
         mb_owe = mb_owe || flush_req;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic step();
      settle();
      tick();
   endtask

   // One complete transaction from master m with immediate downstream handshakes.
   task automatic xact(input bit m, input logic [AW-1:0] a, input logic w,
                       input logic [2:0] s, input logic [DW-1:0] d, input logic [DW-1:0] rd);
      if (m) begin
         m1_cmd_valid = 1; m1_cmd_addr = a; m1_cmd_we = w; m1_cmd_size = s; m1_din = d;
      end else begin
         m0_cmd_valid = 1; m0_cmd_addr = a; m0_cmd_we = w; m0_cmd_size = s; m0_din = d;
      end
      settle();
      chk1("xact_accept", m ? m1_cmd_ready : m0_cmd_ready, 1'b1);
      tick();
      m0_cmd_valid = 0; m1_cmd_valid = 0;
      l2_ch_cmd_ready = 1;
      step();
      l2_ch_cmd_ready = 0;
      l2_ch_valid = 1; l2_ch_dout = rd; m0_ready = 1; m1_ready = 1;
      step();
      l2_ch_valid = 0; m0_ready = 0; m1_ready = 0;
   endtask

   initial begin
      rst = 1;
      m0_cmd_valid = 0; m0_cmd_addr = '0; m0_cmd_we = 0; m0_cmd_size = 3'd3; m0_din = '0; m0_ready = 0;
      m1_cmd_valid = 0; m1_cmd_addr = '0; m1_cmd_we = 0; m1_cmd_size = 3'd3; m1_din = '0; m1_ready = 0;
      flush_req = 0; l2_ch_cmd_ready = 0; l2_ch_valid = 0; l2_ch_dout = '0;
      repeat (2) @(posedge clk);
      #1;

      // Reset state, both masters requesting.
      m0_cmd_valid = 1; m1_cmd_valid = 1;
      m0_cmd_addr = 25'h0000A00; m1_cmd_addr = 25'h0000B00;
      settle();
      chk1("rst_cmd_valid", l2_ch_cmd_valid, 1'b0);
      chk1("rst_flush", l2_ch_flush, 1'b0);
      chk1("rst_flush_ack", flush_ack, 1'b0);
      chk1("rst_l2_ready", l2_ch_ready, 1'b0);
      chk1("rst_m0_valid", m0_valid, 1'b0);
      chk1("rst_m1_valid", m1_valid, 1'b0);
      tick();
      rst = 0;

      // Round-robin order m0,m1,m0,m1 with the other master stalled.
      for (int k = 0; k < 4; k++) begin
         settle();
         chk1("rr_grant_m0", m0_cmd_ready, (k % 2) == 0);
         chk1("rr_grant_m1", m1_cmd_ready, (k % 2) == 1);
         tick();
         l2_ch_cmd_ready = 1;
         settle();
         chk1("rr_stall_m0", m0_cmd_ready, 1'b0);
         chk1("rr_stall_m1", m1_cmd_ready, 1'b0);
         chkw("rr_addr", 32'(l2_ch_cmd_addr), ((k % 2) == 1) ? 32'hB00 : 32'hA00);
         tick();
         l2_ch_cmd_ready = 0;
         l2_ch_valid = 1; l2_ch_dout = 32'(k); m0_ready = 1; m1_ready = 1;
         settle();
         chk1("rr_owner_valid", ((k % 2) == 1) ? m1_valid : m0_valid, 1'b1);
         tick();
         l2_ch_valid = 0; m0_ready = 0; m1_ready = 0;
      end
      m0_cmd_valid = 0; m1_cmd_valid = 0;

      // m1 read held for 3 cycles of downstream back-pressure.
      m1_cmd_valid = 1; m1_cmd_addr = 25'h0000100; m1_cmd_we = 0; m1_cmd_size = 3'd3; m1_din = '0;
      settle();
      chk1("r29_accept", m1_cmd_ready, 1'b1);
      tick();
      m1_cmd_valid = 0;
      for (int c = 0; c < 3; c++) begin
         settle();
         chk1("r29_hold_valid", l2_ch_cmd_valid, 1'b1);
         chkw("r29_hold_addr", 32'(l2_ch_cmd_addr), 32'h100);
         chkw("r29_hold_size", 32'(l2_ch_cmd_size), 32'd3);
         tick();
      end
      l2_ch_cmd_ready = 1;
      step();
      l2_ch_cmd_ready = 0;
      l2_ch_valid = 1; l2_ch_dout = 32'hDEADBEEF; m1_ready = 1;
      settle();
      chk1("r29_m1_valid", m1_valid, 1'b1);
      chkw("r29_m1_dout", m1_dout, 32'hDEADBEEF);
      chk1("r29_m0_valid", m0_valid, 1'b0);
      chkw("r29_m0_dout", m0_dout, 32'd0);
      tick();
      l2_ch_valid = 0; m1_ready = 0;

      // m0 byte write with the response held off by m0 for 2 cycles.
      m0_cmd_valid = 1; m0_cmd_addr = 25'h0000ABC; m0_cmd_we = 1; m0_cmd_size = 3'd1; m0_din = 32'h55;
      step();
      m0_cmd_valid = 0;
      l2_ch_cmd_ready = 1;
      settle();
      chk1("r30_cmd_we", l2_ch_cmd_we, 1'b1);
      tick();
      l2_ch_cmd_ready = 0;
      l2_ch_valid = 1; m0_ready = 0;
      for (int c = 0; c < 2; c++) begin
         settle();
         chk1("r30_l2_ready_low", l2_ch_ready, 1'b0);
         chkw("r30_size", 32'(l2_ch_cmd_size), 32'd1);
         tick();
      end
      m0_ready = 1;
      settle();
      chk1("r30_l2_ready_high", l2_ch_ready, 1'b1);
      tick();
      l2_ch_valid = 0; m0_ready = 0;
      m0_cmd_valid = 1; m0_cmd_we = 0;
      settle();
      chk1("r30_idle_after", m0_cmd_ready, 1'b1);
      m0_cmd_valid = 0;
      tick();

      // Flush arriving during m0's response, m1 waiting.
      m0_cmd_valid = 1; m0_cmd_addr = 25'h0000200; m0_cmd_size = 3'd3;
      step();
      m0_cmd_valid = 0;
      l2_ch_cmd_ready = 1;
      step();
      l2_ch_cmd_ready = 0;
      flush_req = 1; m1_cmd_valid = 1; m1_cmd_addr = 25'h0000300;
      step();
      flush_req = 0;
      l2_ch_valid = 1; m0_ready = 1;
      settle();
      chk1("r31_no_flush_in_resp", l2_ch_flush, 1'b0);
      tick();
      l2_ch_valid = 0; m0_ready = 0;
      settle();
      chk1("r31_pend_block", m1_cmd_ready, 1'b0);
      tick();
      settle();
      chk1("r31_flush", l2_ch_flush, 1'b1);
      chk1("r31_ack", flush_ack, 1'b1);
      chk1("r31_flush_block", m1_cmd_ready, 1'b0);
      tick();
      settle();
      chk1("r31_flush_done", l2_ch_flush, 1'b0);
      chk1("r31_m1_accept", m1_cmd_ready, 1'b1);
      tick();
      m1_cmd_valid = 0;
      l2_ch_cmd_ready = 1;
      step();
      l2_ch_cmd_ready = 0;
      l2_ch_valid = 1; m1_ready = 1;
      step();
      l2_ch_valid = 0; m1_ready = 0;

      // A request during the flush cycle produces a second flush.
      flush_req = 1;
      step();
      flush_req = 0;
      settle();
      chk1("r22_c1", l2_ch_flush, 1'b0);
      tick();
      flush_req = 1;
      settle();
      chk1("r22_c2", l2_ch_flush, 1'b1);
      tick();
      flush_req = 0;
      settle();
      chk1("r22_c3", l2_ch_flush, 1'b0);
      tick();
      settle();
      chk1("r22_c4", l2_ch_flush, 1'b1);
      tick();
      settle();
      chk1("r22_c5", l2_ch_flush, 1'b0);
      tick();

      // Reset during CMD; rr would otherwise favour m1.
      xact(1'b0, 25'h0000400, 1'b0, 3'd2, 32'h0, 32'h1234);
      m0_cmd_valid = 1; m0_cmd_addr = 25'h0000500;
      step();
      m0_cmd_valid = 0;
      settle();
      chk1("r32_in_cmd", l2_ch_cmd_valid, 1'b1);
      rst = 1;
      tick();
      rst = 0; m0_cmd_valid = 1; m1_cmd_valid = 1;
      settle();
      chk1("r32_cmd_valid_low", l2_ch_cmd_valid, 1'b0);
      chk1("r32_m0_first", m0_cmd_ready, 1'b1);
      chk1("r32_m1_wait", m1_cmd_ready, 1'b0);
      tick();
      m0_cmd_valid = 0; m1_cmd_valid = 0;
      l2_ch_cmd_ready = 1;
      step();
      l2_ch_cmd_ready = 0;
      l2_ch_valid = 1; m0_ready = 1;
      step();
      l2_ch_valid = 0; m0_ready = 0;

      // Random traffic, including dropped requests, flushes and occasional reset.
      for (int i = 0; i < 1500; i++) begin
         rst             = ($urandom_range(0, 99) == 0);
         m0_cmd_valid    = ($urandom_range(0, 2) != 0);
         m0_cmd_addr     = AW'($urandom);
         m0_cmd_we       = 1'($urandom_range(0, 1));
         m0_cmd_size     = 3'($urandom_range(1, 3));
         m0_din          = $urandom;
         m1_cmd_valid    = ($urandom_range(0, 2) != 0);
         m1_cmd_addr     = AW'($urandom);
         m1_cmd_we       = 1'($urandom_range(0, 1));
         m1_cmd_size     = 3'($urandom_range(1, 3));
         m1_din          = $urandom;
         m0_ready        = 1'($urandom_range(0, 1));
         m1_ready        = 1'($urandom_range(0, 1));
         flush_req       = ($urandom_range(0, 19) == 0);
         l2_ch_cmd_ready = 1'($urandom_range(0, 1));
         l2_ch_valid     = 1'($urandom_range(0, 1));
         l2_ch_dout      = $urandom;
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/l2_ch_arbiter.md
L2_CH_ARBITER -- requirements
Module: l2_ch_arbiter

Interface
REQ-001 SHALL have parameter AW, default 25, byte address width.
REQ-002 SHALL have parameter DW, default 32, data width; only 32 is supported.
REQ-003 SHALL have ports clk (input, 1, sole clock) and rst (input, 1, synchronous active-high reset); one clock, reset synchronous and active-high.
REQ-004 SHALL have ports mN_cmd_valid (in, 1, command present) and mN_cmd_ready (out, 1, command accepted), for N in {0,1}; master 0 is the I-side, master 1 the D-side.
REQ-005 SHALL have ports mN_cmd_addr (in, AW), mN_cmd_we (in, 1), mN_cmd_size (in, 3; 1=byte, 2=half, 3=word) and mN_din (in, DW), for N in {0,1}.
REQ-006 SHALL have ports mN_valid (out, 1, response valid), mN_ready (in, 1, response taken) and mN_dout (out, DW, response data), for N in {0,1}.
REQ-007 SHALL have ports flush_req (in, 1, flush request pulse) and flush_ack (out, 1, one-cycle flush issued).
REQ-008 SHALL have downstream outputs l2_ch_cmd_valid (1), l2_ch_cmd_addr (AW), l2_ch_cmd_we (1), l2_ch_cmd_size (3), l2_ch_din (DW), l2_ch_ready (1) and l2_ch_flush (1).
REQ-009 SHALL have downstream inputs l2_ch_cmd_ready (1), l2_ch_valid (1) and l2_ch_dout (DW).

Function
REQ-010 SHALL implement FSM states IDLE, CMD, RESP and FLUSH; at most one transaction outstanding downstream.
REQ-011 IDLE, flush pending: SHALL grant no master, assert l2_ch_flush and go to FLUSH.
REQ-012 IDLE, no flush pending: grant = the only valid master; if both are valid, grant = master indicated by round-robin pointer rr.
REQ-013 mN_cmd_ready SHALL be asserted only when state is IDLE, no flush is pending and grant[N] is set (combinational, zero-cycle accept).
REQ-014 On accept, SHALL register addr/we/size/din and owner=N, then go to CMD; l2_ch_cmd_valid SHALL rise the next cycle (1-cycle latency).
REQ-015 In CMD, SHALL drive l2_ch_cmd_valid=1 with the registered fields held stable until l2_ch_cmd_ready=1, then go to RESP.
REQ-016 In RESP, l2_ch_cmd_size SHALL remain equal to the registered size (the downstream dout format depends on it); l2_ch_cmd_valid=0.
REQ-017 In RESP: m[owner]_valid=l2_ch_valid, m[owner]_dout=l2_ch_dout, l2_ch_ready=m[owner]_ready; the non-owner has valid=0 and dout=0.
REQ-018 On l2_ch_valid & l2_ch_ready, SHALL go to IDLE and set rr = ~owner; the next grant is available in that IDLE cycle.
REQ-019 Writes (we=1) SHALL still wait for a downstream response handshake before returning to IDLE.
REQ-020 flush_req SHALL set a sticky flush_pend flag in any state; flush_pend is serviced only in IDLE, so a transaction in progress completes first.
REQ-021 FLUSH lasts one cycle: flush_ack=1, flush_pend cleared, then IDLE; l2_ch_flush is high exactly one cycle per serviced flush.
REQ-022 flush_req arriving while in FLUSH SHALL set flush_pend again, producing a second flush.
REQ-023 Flush SHALL have priority over commands; pending master commands stay un-accepted (ready=0) during flush.
REQ-024 An upstream mN_cmd_valid dropping before accept SHALL have no effect; no command is ever issued twice.

Reset
REQ-025 With rst=1 at a clk edge: state=IDLE, rr=0 (master 0 preferred), owner=0, flush_pend=0.
REQ-026 During and after reset: l2_ch_cmd_valid=0, l2_ch_flush=0, flush_ack=0, l2_ch_ready=0, mN_valid=0; mN_cmd_ready follows REQ-013 from the first non-reset cycle.
REQ-027 Reset mid-transaction SHALL abandon it without completion signalling; registered command fields are don't-care.

Verification
REQ-028 Both masters valid after reset, each transaction completes -> grant order m0,m1,m0,m1; m1 stalls while m0 is in flight.
REQ-029 m1 read addr 0x0000100, size 3; downstream cmd_ready delayed 3 cycles, l2_ch_dout=0xDEADBEEF -> l2_ch_cmd_valid held 3 cycles with fields stable; m1_valid=1, m1_dout=0xDEADBEEF, m0_valid=0.
REQ-030 m0 byte write during RESP with m0_ready=0 for 2 cycles -> l2_ch_ready=0 for those cycles, l2_ch_cmd_size stays 1, IDLE one cycle after the handshake.
REQ-031 flush_req pulse while m0 is in RESP, m1_cmd_valid=1 -> m0 completes, then a single-cycle l2_ch_flush and flush_ack, then m1 is accepted.
REQ-032 rst=1 asserted while in CMD -> next cycle l2_ch_cmd_valid=0, state IDLE; after release, m0 is granted first when both masters are valid.
